// File: rtl/safe_pkg.sv
// Shared key codes, scanner state encoding and entry length for the safe's keypad front end.
package safe_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } scan_state_t;

    // Physical layout: row-major, rows 0..3 top to bottom, columns 0..3 left to right.
    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: return 4'h1;
            4'h1: return 4'h2;
            4'h2: return 4'h3;
            4'h3: return 4'hA;
            4'h4: return 4'h4;
            4'h5: return 4'h5;
            4'h6: return 4'h6;
            4'h7: return 4'hB;
            4'h8: return 4'h7;
            4'h9: return 4'h8;
            4'hA: return 4'h9;
            4'hB: return 4'hC;
            4'hC: return KEY_STAR;
            4'hD: return 4'h0;
            4'hE: return KEY_HASH;
            default: return 4'hD;
        endcase
    endfunction

    function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
        if (!rows[0]) return 2'd0;
        if (!rows[1]) return 2'd1;
        if (!rows[2]) return 2'd2;
        return 2'd3;
    endfunction

    // True when two or more rows are pulled low at once.
    function automatic logic multi_low(input logic [3:0] rows);
        logic [3:0] low;
        low = ~rows;
        return (low & (low - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/keypad_entry_buffer.sv
// Digit entry buffer: shifts in digits, '*' backspaces, '#' on a full entry raises enter_pulse.
module keypad_entry_buffer #(
    parameter int NUM_DIGITS = safe_pkg::NUM_DIGITS
) (
    input  logic                    clk_50mhz,
    input  logic                    rst,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    input  logic                    entry_en,
    input  logic                    clear_entry,
    output logic [4*NUM_DIGITS-1:0] input_data,
    output logic [2:0]              digit_count,
    output logic                    entry_full,
    output logic                    enter_pulse
);
    import safe_pkg::*;

    localparam logic [2:0] FULL_CNT = 3'(NUM_DIGITS);

    assign entry_full = (digit_count == FULL_CNT);

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            input_data  <= '0;
            digit_count <= '0;
            enter_pulse <= 1'b0;
        end else begin
            enter_pulse <= 1'b0;
            // A clear in the same cycle as a key drops that key entirely.
            if (clear_entry) begin
                input_data  <= '0;
                digit_count <= '0;
            end else if (key_valid && entry_en) begin
                if (key_code <= 4'd9) begin
                    if (digit_count < FULL_CNT) begin
                        input_data  <= {input_data[4*NUM_DIGITS-5:0], key_code};
                        digit_count <= digit_count + 3'd1;
                    end
                end else if (key_code == KEY_STAR) begin
                    if (digit_count != 3'd0) begin
                        input_data  <= input_data >> 4;
                        digit_count <= digit_count - 3'd1;
                    end
                end else if (key_code == KEY_HASH) begin
                    enter_pulse <= (digit_count == FULL_CNT);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad scanner with per-tick debounce feeding the safe's BCD entry buffer.
// Build option: KEYPAD_MULTIKEY_REJECT_EN rejects multi-row presses instead of taking the lowest row.
module keypad_entry_scanner #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int SCAN_HZ        = 1000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int NUM_DIGITS     = safe_pkg::NUM_DIGITS
) (
    input  logic                    clk_50mhz,
    input  logic                    rst,
    input  logic [3:0]              key_row,
    output logic [3:0]              key_col,
    input  logic                    entry_en,
    input  logic                    clear_entry,
    output logic                    key_valid,
    output logic [3:0]              key_code,
    output logic [4*NUM_DIGITS-1:0] input_data,
    output logic [2:0]              digit_count,
    output logic                    entry_full,
    output logic                    enter_pulse
);
    import safe_pkg::*;

    localparam int TICK_DIV = CLK_HZ / SCAN_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW       = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_t   state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2, row_lat;
    logic [DW-1:0] db_cnt;

    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign key_col = ~(4'b0001 << col_idx);

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state     <= ST_SCAN;
            tick_cnt  <= '0;
            col_idx   <= 2'd0;
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            row_lat   <= 4'hF;
            db_cnt    <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            // Rows are asynchronous switch contacts; two flops before use.
            row_s1    <= key_row;
            row_s2    <= row_s1;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (row_s2 == 4'hF) begin
                            col_idx <= col_idx + 2'd1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
                        end else if (multi_low(row_s2)) begin
                            col_idx <= col_idx + 2'd1;
`endif
                        end else begin
                            row_lat <= row_s2;
                            db_cnt  <= '0;
                            state   <= ST_DEBOUNCE;
                        end
                    end
                    // A multi-row pattern can never match a single-row latch, so rejection holds here too.
                    ST_DEBOUNCE: begin
                        if (row_s2 != row_lat) begin
                            col_idx <= col_idx + 2'd1;
                            state   <= ST_SCAN;
                        end else if (db_cnt == DW'(DEBOUNCE_SCANS - 1)) begin
                            key_valid <= 1'b1;
                            key_code  <= key_decode(low_row_idx(row_lat), col_idx);
                            state     <= ST_PRESSED;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                    ST_PRESSED: begin
                        db_cnt <= '0;
                        state  <= ST_RELEASE;
                    end
                    default: begin
                        if (row_s2 != 4'hF) begin
                            db_cnt <= '0;
                        end else if (db_cnt == DW'(DEBOUNCE_SCANS - 1)) begin
                            state <= ST_SCAN;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    keypad_entry_buffer #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_buffer (
        .clk_50mhz   (clk_50mhz),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .entry_en    (entry_en),
        .clear_entry (clear_entry),
        .input_data  (input_data),
        .digit_count (digit_count),
        .entry_full  (entry_full),
        .enter_pulse (enter_pulse)
    );

endmodule
